shift_right_seq: RTL and testbench
==================================

SHIFT_RIGHT_SEQ -- requirements
Module: ShiftRightSeq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data path width in bits.
REQ-002 SHALL have parameter SHW, default 5, shift-amount width; WIDTH = 2**SHW.
REQ-003 SHALL have port Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port Start  input  1  request; sampled only in IDLE.
REQ-006 SHALL have port Op  input  2  operation: 00 SRL, 01 SRA, 10 ROR (see REQ-024), 11 reserved.
REQ-007 SHALL have port ShAmt  input  SHW  shift distance, 0..WIDTH-1.
REQ-008 SHALL have port in  input  WIDTH  operand.
REQ-009 SHALL have port shiftedOut  output  WIDTH  registered result.
REQ-010 SHALL have port Busy  output  1  high while in SHIFT.
REQ-011 SHALL have port Done  output  1  one-cycle completion pulse.

Function
REQ-012 SHALL implement three states: IDLE, SHIFT, DONE.
REQ-013 IDLE with Start=1: SHALL capture in, Op and ShAmt into internal registers; next state SHIFT if ShAmt!=0, else DONE.
REQ-014 SHIFT: each cycle SHALL shift the working register right by exactly one bit and decrement the count; when count reaches 0, next state SHALL be DONE.
REQ-015 Shift fill: SRL inserts 0; SRA inserts the captured operand bit WIDTH-1; Op=11 SHALL behave as SRL.
REQ-016 On entry to DONE, shiftedOut SHALL load the working register; Done=1 for exactly one cycle; next state IDLE unconditionally.
REQ-017 Latency: Done SHALL assert ShAmt+1 cycles after the edge that samples Start (ShAmt=0 gives 1 cycle).
REQ-018 shiftedOut SHALL hold its value from one DONE until the next DONE; it SHALL NOT change during SHIFT.
REQ-019 Start while in SHIFT or DONE SHALL be ignored; captured operands SHALL NOT change.
REQ-020 Start asserted in the cycle Done is high SHALL be ignored; a new operation starts only from IDLE, giving a minimum 1-cycle gap between Done and the next capture.
REQ-021 Changes on in/Op/ShAmt after capture SHALL NOT affect the result in progress.

Reset
REQ-022 Reset=1 at a rising edge SHALL force state IDLE, shiftedOut=0, Busy=0, Done=0, clear the count and working registers; Reset SHALL take priority over Start.
REQ-023 Reset during SHIFT SHALL abort the operation with no Done pulse; shiftedOut SHALL read 0.

Configuration
REQ-024 Macro SHIFT_ROTATE_EN: when defined, Op=10 SHALL rotate right, with bit 0 re-entering at bit WIDTH-1 each cycle; when undefined, Op=10 SHALL behave as SRL and no rotate logic SHALL be synthesized.

Verification
REQ-025 SRL, in=0x80000000, ShAmt=4 -> Done at cycle 5 after Start, shiftedOut=0x08000000, Busy high for cycles 1-4.
REQ-026 SRA, in=0x80000000, ShAmt=31 -> Done at cycle 32, shiftedOut=0xFFFFFFFF; SRA in=0x40000000, ShAmt=31 -> 0x00000000.
REQ-027 ShAmt=0, in=0xDEADBEEF, any Op -> Done at cycle 1, shiftedOut=0xDEADBEEF, Busy never high.
REQ-028 Start SRL in=0xF0000000 ShAmt=8; at cycle 3 pulse Start with in=0x1 ShAmt=1 -> second request ignored, shiftedOut=0x00F00000 at cycle 9; Start held high through Done -> next capture only in the following IDLE cycle.
REQ-029 Reset asserted at cycle 3 of SRL ShAmt=10 -> no Done, shiftedOut=0, Busy=0 next cycle; a fresh SRL in=0x100 ShAmt=8 then yields 0x1 with normal latency.
REQ-030 Op=10, in=0x00000001, ShAmt=1 -> 0x80000000 with SHIFT_ROTATE_EN, 0x00000000 without; in=0x12345678, ShAmt=8 -> 0x78123456 with macro.

Source files
------------

// File: rtl/shift_right_seq.sv
// Multi-cycle right shifter: one bit per cycle, SRL/SRA, optional rotate.
// Define SHIFT_ROTATE_EN to make Op=2'b10 rotate right; otherwise it acts as SRL.
module shift_right_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [SHW-1:0]   ShAmt,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] shiftedOut,
    output logic             Busy,
    output logic             Done,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [SHW-1:0] CNT_ONE = SHW'(1);

    state_e           state_q, state_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [1:0]       op_q, op_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             fill;
    logic [WIDTH-1:0] shr;

    // SRA keeps re-inserting the MSB, which never changes under SRA, so the
    // working register's top bit always equals the captured operand's sign.
    always_comb begin
        fill = 1'b0;
        case (op_q)
            2'b01:   fill = work_q[WIDTH-1];
`ifdef SHIFT_ROTATE_EN
            2'b10:   fill = work_q[0];
`endif
            default: fill = 1'b0;
        endcase
        shr = {fill, work_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        result_d = result_q;
        op_d     = op_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    work_d = in;
                    op_d   = Op;
                    cnt_d  = ShAmt;
                    if (ShAmt == '0) begin
                        state_d  = DONE;
                        done_d   = 1'b1;
                        result_d = in;
                    end else begin
                        state_d = SHIFT;
                        busy_d  = 1'b1;
                    end
                end
            end
            SHIFT: begin
                work_d = shr;
                cnt_d  = cnt_q - CNT_ONE;
                // The last shift and the result load share one edge.
                if (cnt_q == CNT_ONE) begin
                    state_d  = DONE;
                    done_d   = 1'b1;
                    result_d = shr;
                end else begin
                    busy_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            work_q   <= '0;
            result_q <= '0;
            op_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            work_q   <= work_d;
            result_q <= result_d;
            op_q     <= op_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign shiftedOut = result_q;
    assign Busy       = busy_q;
    assign Done       = done_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_shift_right_seq.sv
// Directed bench for shift_right_seq: driver pushes expected result and Done
// cycle into queues; a monitor pops on Done and checks hold/Busy every cycle.
module tb_shift_right_seq;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic [1:0]  Op = 2'b00;
    logic [4:0]  ShAmt = 5'd0;
    logic [31:0] in_d = 32'd0;
    logic [31:0] shiftedOut;
    logic        Busy;
    logic        Done;
    logic [1:0]  state_dbg;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    int          cyc_q[$];
    logic [31:0] model_out = 32'd0;
    int          c0;

    shift_right_seq #(.WIDTH(32), .SHW(5)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .ShAmt(ShAmt),
        .in(in_d), .shiftedOut(shiftedOut), .Busy(Busy), .Done(Done),
        .state_dbg(state_dbg)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic monitor_loop();
        logic [31:0] ev;
        int          ec;
        logic        bexp;
        forever begin
            @(negedge Clk);
            if (Done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    ev = exp_q.pop_front();
                    ec = cyc_q.pop_front();
                    check("result", shiftedOut, ev);
                    check("done_cycle", 32'(cyc), 32'(ec));
                    model_out = ev;
                end
            end else begin
                check("hold_out", shiftedOut, model_out);
            end
            bexp = (cyc_q.size() > 0) && (cyc < cyc_q[0]);
            check("busy", {31'd0, Busy}, {31'd0, bexp});
        end
    endtask

    task automatic wait_done(input int limit);
        int n;
        bit got;
        n = 0;
        got = 1'b0;
        while (!got && n < limit) begin
            @(negedge Clk);
            n++;
            if (Done === 1'b1) got = 1'b1;
        end
        if (!got) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic issue(input logic [1:0] op, input logic [4:0] amt, input logic [31:0] data);
        @(negedge Clk);
        Start = 1'b1;
        Op    = op;
        ShAmt = amt;
        in_d  = data;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [4:0] amt,
                          input logic [31:0] data, input logic [31:0] exp);
        issue(op, amt, data);
        @(posedge Clk);
        #1;
        c0 = cyc;
        exp_q.push_back(exp);
        cyc_q.push_back(c0 + int'(amt));
        Start = 1'b0;
        in_d  = $urandom;
        Op    = 2'($urandom_range(0, 3));
        ShAmt = 5'($urandom_range(0, 31));
        wait_done(int'(amt) + 5);
    endtask

    task automatic wait_until(input int target);
        @(negedge Clk);
        while (cyc < target) @(negedge Clk);
    endtask

    initial begin
        fork
            monitor_loop();
        join_none

        repeat (3) @(posedge Clk);
        #1;
        @(negedge Clk);
        check("reset_out", shiftedOut, 32'd0);
        check("reset_busy", {31'd0, Busy}, 32'd0);
        check("reset_done", {31'd0, Done}, 32'd0);
        check("reset_state", {30'd0, state_dbg}, 32'd0);
        Reset = 1'b0;

        run_op(2'b00, 5'd4,  32'h8000_0000, 32'h0800_0000);
        run_op(2'b01, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(2'b01, 5'd31, 32'h4000_0000, 32'h0000_0000);
        for (int o = 0; o < 4; o++) run_op(o[1:0], 5'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        run_op(2'b11, 5'd4,  32'h8000_0000, 32'h0800_0000);
        run_op(2'b01, 5'd4,  32'hF0F0_F0F0, 32'hFF0F_0F0F);
        run_op(2'b00, 5'd31, 32'hFFFF_FFFF, 32'h0000_0001);
`ifdef SHIFT_ROTATE_EN
        run_op(2'b10, 5'd1,  32'h0000_0001, 32'h8000_0000);
        run_op(2'b10, 5'd8,  32'h1234_5678, 32'h7812_3456);
`else
        run_op(2'b10, 5'd1,  32'h0000_0001, 32'h0000_0000);
        run_op(2'b10, 5'd8,  32'h1234_5678, 32'h0012_3456);
`endif

        // Start pulses during SHIFT and held through DONE must be ignored.
        issue(2'b00, 5'd8, 32'hF000_0000);
        @(posedge Clk);
        #1;
        c0 = cyc;
        exp_q.push_back(32'h00F0_0000);
        cyc_q.push_back(c0 + 8);
        Start = 1'b0;
        wait_until(c0 + 2);
        Start = 1'b1;
        in_d  = 32'h0000_0001;
        ShAmt = 5'd1;
        @(negedge Clk);
        Start = 1'b0;
        wait_until(c0 + 5);
        Start = 1'b1;
        Op    = 2'b00;
        in_d  = 32'h0000_FF00;
        ShAmt = 5'd4;
        while (cyc < c0 + 10) begin
            @(posedge Clk);
            #1;
        end
        exp_q.push_back(32'h0000_0FF0);
        cyc_q.push_back(c0 + 14);
        Start = 1'b0;
        wait_done(10);

        // Reset in the middle of a shift aborts with no Done.
        issue(2'b00, 5'd10, 32'hFFFF_FFFF);
        @(posedge Clk);
        #1;
        c0 = cyc;
        exp_q.push_back(32'h003F_FFFF);
        cyc_q.push_back(c0 + 10);
        Start = 1'b0;
        wait_until(c0 + 2);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        exp_q.delete();
        cyc_q.delete();
        model_out = 32'd0;
        @(negedge Clk);
        Reset = 1'b0;
        check("abort_busy", {31'd0, Busy}, 32'd0);
        check("abort_out", shiftedOut, 32'd0);
        check("abort_state", {30'd0, state_dbg}, 32'd0);
        repeat (15) @(negedge Clk);
        run_op(2'b00, 5'd8, 32'h0000_0100, 32'h0000_0001);

        repeat (3) @(negedge Clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
